bcd_hex_display: RTL and testbench



---
 rtl/bcd_hex_display_pkg.sv | 36 +++
 rtl/bcd_hex_display_seg7_decode.sv | 34 +++
 rtl/bcd_hex_display.sv | 131 +++++++++++++
 tb/tb_bcd_hex_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_hex_display_pkg.sv
//------------------------------------------------------------------------------
// Module   : bcd_hex_display_pkg
// Brief    : Shared segment codes, FSM states and BCD adjust helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bcd_hex_display_pkg;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [3:0] add3_adjust(input logic [3:0] i_nib);
    return (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_hex_display_seg7_decode.sv
//------------------------------------------------------------------------------
// Module   : bcd_hex_display_seg7_decode
// Brief    : Combinational 4-bit digit to active-low 7-segment pattern.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_hex_display_seg7_decode
  import bcd_hex_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_hex_display.sv
//------------------------------------------------------------------------------
// Module   : bcd_hex_display
// Brief    : Iterative double-dabble of an output-port word onto 7-seg displays.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_hex_display
  import bcd_hex_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           value,
  output logic [7*DIGITS-1:0]   hex,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  overflow
);

  localparam int ACC_W = 4*DIGITS + 4;
  localparam int CNT_W = 6;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_shadow;
  logic [WIDTH-1:0]    r_bin;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_force;
  logic                r_lost;
  logic [7*DIGITS-1:0] r_hex;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_busy;
  logic                r_ovf;

  logic [WIDTH-1:0]    w_value;
  logic                w_unused_value;
  logic                w_start;
  logic                w_last;
  logic                w_ovf;
  logic [ACC_W-1:0]    w_adj;
  logic [7*DIGITS-1:0] w_seg;

  assign w_value        = value[WIDTH-1:0];
  assign w_unused_value = ^value;
  assign w_start        = (r_state == IDLE) && ((w_value != r_shadow) || r_force);
  assign w_last         = (r_cnt == CNT_W'(WIDTH - 1));
  // A carry out of the guard nibble is remembered so huge values still flag overflow
  assign w_ovf          = (r_acc[ACC_W-1 -: 4] != 4'd0) || r_lost;

  always_comb begin
    w_adj = '0;
    for (int k = 0; k <= DIGITS; k++) begin
      w_adj[4*k +: 4] = add3_adjust(r_acc[4*k +: 4]);
    end
  end

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_hex_display_seg7_decode u_seg (
        .i_digit (r_acc[4*k +: 4]),
        .o_seg   (w_seg[7*k +: 7])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shadow <= '0;
      r_bin    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_force  <= 1'b1;
      r_lost   <= 1'b0;
      r_hex    <= {DIGITS{SEG_BLANK}};
      r_bcd    <= '0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_shadow <= w_value;
          r_bin    <= w_value;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_force  <= 1'b0;
          r_lost   <= 1'b0;
          r_busy   <= 1'b1;
        end
        SHIFT: begin
          {r_acc, r_bin} <= {w_adj, r_bin} << 1;
          r_lost         <= r_lost | w_adj[ACC_W-1];
          r_cnt          <= r_cnt + 6'd1;
        end
        DONE: begin
          r_bcd  <= r_acc[4*DIGITS-1:0];
          r_ovf  <= w_ovf;
          r_hex  <= w_ovf ? {DIGITS{SEG_DASH}} : w_seg;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign hex      = r_hex;
  assign bcd      = r_bcd;
  assign busy     = r_busy;
  assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bcd_hex_display.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd_hex_display
// Brief    : Scoreboard bench for bcd_hex_display (8/2 and 4/1 configurations).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_hex_display;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] value = '0;
  logic [31:0] value_s = '0;
  logic [13:0] hex;
  logic [7:0]  bcd;
  logic        busy, overflow;
  logic [6:0]  hex_s;
  logic [3:0]  bcd_s;
  logic        busy_s, overflow_s;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct packed {
    logic [13:0] hex;
    logic [7:0]  bcd;
    logic        ovf;
    logic [31:0] start;
    logic        chk_lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  bcd_hex_display #(.WIDTH(8), .DIGITS(2)) dut (
    .clock(clock), .reset(reset), .value(value),
    .hex(hex), .bcd(bcd), .busy(busy), .overflow(overflow)
  );

  bcd_hex_display #(.WIDTH(4), .DIGITS(1)) dut_s (
    .clock(clock), .reset(reset), .value(value_s),
    .hex(hex_s), .bcd(bcd_s), .busy(busy_s), .overflow(overflow_s)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, required completion before 100000");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b1000000;  1: seg = 7'b1111001;
      2: seg = 7'b0100100;  3: seg = 7'b0110000;
      4: seg = 7'b0011001;  5: seg = 7'b0010010;
      6: seg = 7'b0000010;  7: seg = 7'b1111000;
      8: seg = 7'b0000000;  9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] v, input int width, input int digits);
    exp_t e;
    int   q;
    int   p;
    e = '0;
    q = int'(v & ((32'd1 << width) - 32'd1));
    p = 1;
    for (int d = 0; d < digits; d++) begin
      e.bcd[4*d +: 4] = 4'((q / p) % 10);
      e.hex[7*d +: 7] = seg((q / p) % 10);
      p = p * 10;
    end
    e.ovf = (q >= p);
    if (e.ovf) begin
      for (int d = 0; d < digits; d++) e.hex[7*d +: 7] = 7'b0111111;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int sel, input logic [31:0] v, input logic lat);
    exp_t e;
    if (sel == 0) begin
      value = v;
      e = model(v, 8, 2);
    end else begin
      value_s = v;
      e = model(v, 4, 1);
    end
    e.start   = cyc;
    e.chk_lat = lat;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic await_done(input int sel, input string tag);
    logic prev;
    logic cur;
    logic done;
    int   n;
    exp_t e;
    prev = (sel == 0) ? busy : busy_s;
    done = 1'b0;
    n    = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
      cur = (sel == 0) ? busy : busy_s;
      if (prev && !cur) done = 1'b1;
      prev = cur;
    end
    if (sel == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (!done) return;
    if (sel == 0) begin
      chk({tag, "_hex"}, 32'(hex), 32'(e.hex));
      chk({tag, "_bcd"}, 32'(bcd), 32'(e.bcd));
      chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
    end else begin
      chk({tag, "_hex"}, 32'(hex_s), 32'(e.hex[6:0]));
      chk({tag, "_bcd"}, 32'(bcd_s), 32'(e.bcd[3:0]));
      chk({tag, "_ovf"}, 32'(overflow_s), 32'(e.ovf));
    end
    if (e.chk_lat) chk({tag, "_lat"}, cyc - e.start, (sel == 0) ? 32'd10 : 32'd6);
  endtask

  initial begin
    int hi;

    repeat (2) @(negedge clock);
    chk("rst_hex", 32'(hex), 32'h3fff);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_hex_s", 32'(hex_s), 32'h7f);
    chk("rst_busy_s", 32'(busy_s), 32'h0);

    // Release reset with value 0: only the force flag can start this conversion
    reset = 1'b0;
    drive(0, 32'd0, 1'b1);
    repeat (9) @(negedge clock);
    chk("e9_blank", 32'(hex), 32'h3fff);
    chk("e9_busy", 32'(busy), 32'h1);
    await_done(0, "zero");

    drive(0, 32'd37, 1'b1);
    await_done(0, "v37");
    hi = 0;
    repeat (50) begin
      @(negedge clock);
      if (busy) hi++;
    end
    chk("hold37_quiet", 32'(hi), 32'd0);

    value = 32'h0000_0125;
    hi = 0;
    repeat (20) begin
      @(negedge clock);
      if (busy) hi++;
    end
    chk("upper_quiet", 32'(hi), 32'd0);
    chk("upper_bcd", 32'(bcd), 32'h37);

    drive(0, 32'hFFFF_FF2A, 1'b1);
    await_done(0, "v42hi");
    drive(0, 32'd100, 1'b1);
    await_done(0, "v100");
    drive(0, 32'd99, 1'b1);
    await_done(0, "v99");
    drive(0, 32'd255, 1'b1);
    await_done(0, "v255");

    // Change value mid-conversion: first result stands, second follows one idle cycle later
    drive(0, 32'd12, 1'b1);
    repeat (3) @(negedge clock);
    drive(0, 32'd45, 1'b0);
    await_done(0, "v12");
    @(negedge clock);
    chk("rearm_busy", 32'(busy), 32'h1);
    await_done(0, "v45");

    value = 32'd0;
    repeat (5) @(negedge clock);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_hex", 32'(hex), 32'h3fff);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_bcd", 32'(bcd), 32'h0);
    chk("midrst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    drive(0, 32'd0, 1'b1);
    await_done(0, "force");

    for (int i = 1; i <= 16; i++) begin
      drive(1, 32'(i % 16), 1'b1);
      await_done(1, "sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
